// File: rtl/free_list_mp.sv
// Free physical-register list for a rename stage: circular buffer with speculative
// and architectural heads, so a flush can roll back every uncommitted allocation.
module free_list_mp #(
  parameter int PRF_DEPTH = 64,
  parameter int ARF_DEPTH = 32,
  parameter int DEQ_WIDTH = 1,
  parameter int ENQ_WIDTH = 1,
  localparam int FL_DEPTH = PRF_DEPTH - ARF_DEPTH,
  localparam int PRF_IDX  = $clog2(PRF_DEPTH),
  localparam int CNT_W    = $clog2(FL_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DEQ_WIDTH-1:0]         alloc_req,
  output logic                         alloc_ready,
  output logic [DEQ_WIDTH*PRF_IDX-1:0] alloc_phy,
  input  logic [ENQ_WIDTH-1:0]         free_valid,
  input  logic [ENQ_WIDTH*PRF_IDX-1:0] free_phy,
  input  logic [ENQ_WIDTH-1:0]         commit_alloc,
  input  logic                         flush,
  output logic [CNT_W-1:0]             free_count
);
  localparam int IDX_W = CNT_W - 1;
  localparam logic [CNT_W:0]   FL_DEPTH_X = (CNT_W+1)'(FL_DEPTH);
  localparam logic [CNT_W-1:0] FL_DEPTH_C = CNT_W'(FL_DEPTH);
  localparam logic [CNT_W-1:0] DEQ_W_C    = CNT_W'(DEQ_WIDTH);

  // Pointers are {wrap, index}; the index wraps at FL_DEPTH, which need not be a power of 2.
  function automatic logic [CNT_W-1:0] ptr_add(input logic [CNT_W-1:0] p,
                                               input logic [CNT_W-1:0] n);
    logic [CNT_W:0] sum;
    logic           wrap;
    sum  = {2'b00, p[IDX_W-1:0]} + {1'b0, n};
    wrap = p[CNT_W-1];
    if (sum >= FL_DEPTH_X) begin
      sum  = sum - FL_DEPTH_X;
      wrap = ~wrap;
    end
    return {wrap, sum[IDX_W-1:0]};
  endfunction

  function automatic logic [CNT_W-1:0] count_of(input logic [CNT_W-1:0] t,
                                                input logic [CNT_W-1:0] h);
    logic [CNT_W-1:0] ti, hi, c;
    ti = {1'b0, t[IDX_W-1:0]};
    hi = {1'b0, h[IDX_W-1:0]};
    if (t[CNT_W-1] == h[CNT_W-1]) c = ti - hi;
    else                          c = FL_DEPTH_C + ti - hi;
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] popcnt_deq(input logic [DEQ_WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] popcnt_enq(input logic [ENQ_WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  logic [PRF_IDX-1:0] entries [FL_DEPTH];
  logic [CNT_W-1:0]   spec_head, arch_head, tail;
  logic [CNT_W-1:0]   spec_nxt, arch_nxt, tail_nxt;
  logic [CNT_W-1:0]   rd_ptr [DEQ_WIDTH];
  logic [CNT_W-1:0]   wr_ptr [ENQ_WIDTH];
  logic [CNT_W-1:0]   rd_off, wr_off;
  logic               alloc_fire;

  assign alloc_ready = (free_count >= DEQ_W_C) && !flush;
  assign alloc_fire  = alloc_ready && |alloc_req;

  always_comb begin
    rd_off    = '0;
    wr_off    = '0;
    alloc_phy = '0;
    // Requested lanes read consecutive entries; idle lanes show their natural slot.
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      rd_ptr[i] = ptr_add(spec_head, alloc_req[i] ? rd_off : CNT_W'(i));
      alloc_phy[i*PRF_IDX +: PRF_IDX] = entries[rd_ptr[i][IDX_W-1:0]];
      if (alloc_req[i]) rd_off = rd_off + 1'b1;
    end
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      wr_ptr[i] = ptr_add(tail, wr_off);
      if (free_valid[i]) wr_off = wr_off + 1'b1;
    end
    arch_nxt = ptr_add(arch_head, popcnt_enq(commit_alloc));
    tail_nxt = ptr_add(tail, popcnt_enq(free_valid));
    if (flush)           spec_nxt = arch_nxt;
    else if (alloc_fire) spec_nxt = ptr_add(spec_head, popcnt_deq(alloc_req));
    else                 spec_nxt = spec_head;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      spec_head  <= '0;
      arch_head  <= '0;
      tail       <= {1'b1, {IDX_W{1'b0}}};
      free_count <= FL_DEPTH_C;
      for (int j = 0; j < FL_DEPTH; j++) entries[j] <= PRF_IDX'(ARF_DEPTH + j);
    end else begin
      spec_head  <= spec_nxt;
      arch_head  <= arch_nxt;
      tail       <= tail_nxt;
      free_count <= count_of(tail_nxt, spec_nxt);
      for (int i = 0; i < ENQ_WIDTH; i++)
        if (free_valid[i]) entries[wr_ptr[i][IDX_W-1:0]] <= free_phy[i*PRF_IDX +: PRF_IDX];
    end
  end
endmodule

// File: tb/tb_free_list_mp.sv
// Bench for free_list_mp: directed scenarios with literal expectations, then random
// traffic compared every cycle against an unbounded-pointer reference model.
module tb_free_list_mp;
  localparam int DW = 2;
  localparam int FL = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  alloc_req;
  logic        alloc_ready;
  logic [11:0] alloc_phy;
  logic [1:0]  free_valid;
  logic [11:0] free_phy;
  logic [1:0]  commit_alloc;
  logic        flush;
  logic [5:0]  free_count;

  always #5 clk = ~clk;

  free_list_mp #(.PRF_DEPTH(64), .ARF_DEPTH(32), .DEQ_WIDTH(2), .ENQ_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_ready(alloc_ready),
    .alloc_phy(alloc_phy), .free_valid(free_valid), .free_phy(free_phy),
    .commit_alloc(commit_alloc), .flush(flush), .free_count(free_count));

  int checks = 0;
  int failures = 0;

  // Reference model: ever-increasing pointers, slot = pointer mod FL.
  int m_sp, m_ah, m_tl;
  int m_mem [FL];
  bit m_ok = 1'b0;

  function automatic int pc2(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic compare_model();
    int cnt, below;
    bit rdy;
    if (!m_ok || !rst) return;
    cnt = m_tl - m_sp;
    check("model_count_range", (cnt >= 0 && cnt <= FL), 1);
    check("free_count", free_count, cnt);
    rdy = (cnt >= DW) && !flush;
    check("alloc_ready", alloc_ready, rdy);
    if (rdy) begin
      below = 0;
      for (int i = 0; i < DW; i++)
        if (alloc_req[i]) begin
          check("alloc_phy", alloc_phy[i*6 +: 6], m_mem[(m_sp + below) % FL]);
          below++;
        end
    end
  endtask

  task automatic model_update();
    int cnt, k;
    bit fire;
    if (!rst) begin
      for (int j = 0; j < FL; j++) m_mem[j] = 32 + j;
      m_sp = 0; m_ah = 0; m_tl = FL; m_ok = 1'b1;
      return;
    end
    if (!m_ok) return;
    cnt  = m_tl - m_sp;
    fire = (cnt >= DW) && !flush && (alloc_req != 2'b00);
    k = 0;
    for (int i = 0; i < 2; i++)
      if (free_valid[i]) begin
        m_mem[(m_tl + k) % FL] = int'(free_phy[i*6 +: 6]);
        k++;
      end
    m_ah = m_ah + pc2(commit_alloc);
    if (flush)     m_sp = m_ah;
    else if (fire) m_sp = m_sp + pc2(alloc_req);
    m_tl = m_tl + k;
    check("legal_free_count", (m_tl - m_sp <= FL), 1);
  endtask

  task automatic cyc();
    #1 compare_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_req = '0; free_valid = '0; free_phy = '0; commit_alloc = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    cyc();
    rst = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    #1;
    check({tag, "_free_count"}, free_count, 32);
    check({tag, "_alloc_ready"}, alloc_ready, 1);
    check({tag, "_alloc_phy"}, alloc_phy, {6'd33, 6'd32});
  endtask

  initial begin
    logic [1:0] cm, fv;
    int ahn;
    rst = 1'b0;
    idle();
    repeat (2) cyc();
    rst = 1'b1;
    check_reset_state("reset");
    check("model_reset_count", m_tl - m_sp, 32);

    // Single-lane grants pick the head entry regardless of lane position.
    do_reset();
    alloc_req = 2'b10;
    #1 check("lane1_first", alloc_phy[11:6], 32);
    cyc();
    alloc_req = 2'b01;
    #1 check("count_after_one", free_count, 31);
    check("lane0_second", alloc_phy[5:0], 33);
    cyc();
    idle();

    // Drain completely, then two returns become allocatable on the next cycle.
    do_reset();
    alloc_req = 2'b11;
    repeat (16) cyc();
    idle();
    #1 check("drained_count", free_count, 0);
    check("drained_ready", alloc_ready, 0);
    free_valid = 2'b11;
    free_phy = {6'd9, 6'd5};
    #1 check("no_bypass_ready", alloc_ready, 0);
    cyc();
    idle();
    #1 check("refill_count", free_count, 2);
    check("refill_ready", alloc_ready, 1);
    check("refill_phy", alloc_phy, {6'd9, 6'd5});

    // Flush rolls the speculative head back to the committed point.
    do_reset();
    alloc_req = 2'b11;
    repeat (3) cyc();
    idle();
    commit_alloc = 2'b11;
    cyc();
    idle();
    flush = 1'b1;
    #1 check("flush_blocks_ready", alloc_ready, 0);
    cyc();
    idle();
    #1 check("flush_count", free_count, 30);
    check("flush_phy0", alloc_phy[5:0], 34);
    check("model_flush_count", m_tl - m_sp, 30);

    // Free and commit during a flush; the returned 40 surfaces after wrap.
    flush = 1'b1; commit_alloc = 2'b01; free_valid = 2'b01; free_phy = 12'd40; alloc_req = 2'b11;
    cyc();
    idle();
    #1 check("flush_free_count", free_count, 30);
    check("flush_free_phy0", alloc_phy[5:0], 35);
    alloc_req = 2'b11;
    repeat (14) cyc();
    #1 check("wrapped_entry", alloc_phy[11:6], 40);
    cyc();
    idle();

    // Random traffic; frees and commits are kept within the legal envelope.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      alloc_req = 2'($urandom_range(0, 3));
      flush = ($urandom_range(0, 19) == 0);
      cm = 2'($urandom_range(0, 3));
      while (pc2(cm) > m_sp - m_ah) cm = cm & (cm - 2'd1);
      commit_alloc = cm;
      ahn = m_ah + pc2(cm);
      fv = 2'($urandom_range(0, 3));
      while (m_tl + pc2(fv) > ahn + FL) fv = fv & (fv - 2'd1);
      free_valid = fv;
      free_phy = 12'($urandom);
      cyc();
    end
    check("tail_wrapped_twice", (m_tl >= FL + 2 * FL), 1);

    // Reset wins over simultaneous flush, alloc and free.
    rst = 1'b0; flush = 1'b1; alloc_req = 2'b11; free_valid = 2'b11;
    free_phy = {6'd7, 6'd3}; commit_alloc = 2'b11;
    cyc();
    rst = 1'b1;
    idle();
    check_reset_state("midrun_reset");
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
